// File: rtl/cl_irq_pkg.sv
// Shared types, default sizes and helpers for the interrupt upstream controller.
package cl_irq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } irq_st_t;

    localparam int DEF_NUM_IRQ     = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_ACK_TIMEOUT = 1024;

    // Width of the ack timer; a disabled timeout still gets a 1-bit register.
    function automatic int tmr_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cl_irq_chan.sv
// One interrupt channel: input synchroniser, edge/level event detect,
// pending/count/err bookkeeping and the req/ack handshake FSM with timer.
module cl_irq_chan
    import cl_irq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq_in,
    input  logic             mask,
    input  logic             level_mode,
    input  logic             pop,
    input  logic             ack,
    output logic             status,
    output logic [CNT_W-1:0] count,
    output logic             err,
    output logic             req
);

    localparam int TW = tmr_width(ACK_TIMEOUT);
    localparam logic [TW-1:0] TMR_LOAD = (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : '0;

    logic             irq_s;
    logic             irq_q, irq_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             arm_q, arm_d;
    irq_st_t          state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             evt;
    logic             go_req;
    logic             expire;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign irq_s = irq_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;

            // Shift the raw input through the synchroniser chain.
            always_comb sync_d = SYNC_STAGES'({sync_q, irq_in});

            // Synchroniser flops.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) sync_q <= '0;
                else       sync_q <= sync_d;
            end

            assign irq_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Level mode fires whenever the line is high and nothing is pending, so a
    // held level only re-triggers once software pops the channel.
    assign evt = irq_s & (level_mode ? ~pending_q : ~irq_q);

    // Event bookkeeping; an event in the same cycle as a pop wins and counts as the first.
    always_comb begin
        irq_d     = irq_s;
        pending_d = pending_q;
        count_d   = count_q;
        arm_d     = arm_q;
        err_d     = (err_q & ~pop) | expire;
        if (go_req) arm_d = 1'b0;
        if (pop) begin
            pending_d = 1'b0;
            count_d   = '0;
            arm_d     = 1'b0;
        end
        if (evt) begin
            pending_d = 1'b1;
            arm_d     = 1'b1;
            if (pop)                 count_d = CNT_W'(1);
            else if (count_q != '1)  count_d = count_q + CNT_W'(1);
        end
    end

    // Channel bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q     <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            irq_q     <= irq_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
            arm_q     <= arm_d;
        end
    end

    // Handshake state and ack timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state: the mask only gates leaving IDLE, never an ongoing handshake.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        go_req  = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm_q && !mask) begin
                    state_d = REQ;
                    go_req  = 1'b1;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_ACK;
                    timer_d = TMR_LOAD;
                end
            end
            WAIT_ACK: begin
                if (ack) begin
                    state_d = IDLE;
                end else if ((ACK_TIMEOUT > 0) && (timer_q == '0)) begin
                    state_d = REQ;
                    expire  = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from flops.
    always_comb begin
        req    = (state_q == REQ);
        status = pending_q;
        count  = count_q;
        err    = err_q;
    end

endmodule

// File: rtl/cl_irq_upstream_mc.sv
// Multi-channel interrupt upstream controller: NUM_IRQ independent channels
// feeding the shell's per-channel irq_req/irq_ack handshake.
module cl_irq_upstream_mc
    import cl_irq_pkg::*;
#(
    parameter int NUM_IRQ     = DEF_NUM_IRQ,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IRQ-1:0]       irq_in,
    input  logic [NUM_IRQ-1:0]       irq_mask,
    input  logic [NUM_IRQ-1:0]       irq_level_mode,
    input  logic [NUM_IRQ-1:0]       irq_pop,
    output logic [NUM_IRQ-1:0]       irq_status,
    output logic [NUM_IRQ*CNT_W-1:0] irq_count,
    output logic [NUM_IRQ-1:0]       irq_err,
    output logic [NUM_IRQ-1:0]       irq_req,
    input  logic [NUM_IRQ-1:0]       irq_ack
);

    generate
        for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
            cl_irq_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .CNT_W       (CNT_W),
                .ACK_TIMEOUT (ACK_TIMEOUT)
            ) u_chan (
                .clk        (clk),
                .reset      (reset),
                .irq_in     (irq_in[i]),
                .mask       (irq_mask[i]),
                .level_mode (irq_level_mode[i]),
                .pop        (irq_pop[i]),
                .ack        (irq_ack[i]),
                .status     (irq_status[i]),
                .count      (irq_count[i*CNT_W +: CNT_W]),
                .err        (irq_err[i]),
                .req        (irq_req[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_cl_irq_upstream_mc.sv
// Bench for cl_irq_upstream_mc: directed scenarios plus random traffic, all
// outputs scored every cycle against a behavioural per-channel model.
module tb_cl_irq_upstream_mc;

    localparam int NI = 8;
    localparam int CW = 8;
    localparam int TO = 8;
    localparam int SS = 0;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NI-1:0]     irq_in, irq_mask, irq_level_mode, irq_pop, irq_ack;
    logic [NI-1:0]     irq_status, irq_err, irq_req;
    logic [NI*CW-1:0]  irq_count;

    always #5 clk = ~clk;

    cl_irq_upstream_mc #(
        .NUM_IRQ     (NI),
        .SYNC_STAGES (SS),
        .CNT_W       (CW),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .irq_in         (irq_in),
        .irq_mask       (irq_mask),
        .irq_level_mode (irq_level_mode),
        .irq_pop        (irq_pop),
        .irq_status     (irq_status),
        .irq_count      (irq_count),
        .irq_err        (irq_err),
        .irq_req        (irq_req),
        .irq_ack        (irq_ack)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int req_cnt [NI];
    int t6 [$];

    typedef struct {
        logic [NI-1:0]    st;
        logic [NI-1:0]    er;
        logic [NI-1:0]    rq;
        logic [NI*CW-1:0] cn;
    } exp_t;
    exp_t exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return irq_count[ch*CW +: CW];
    endfunction

    // Reference model: per channel, who owes a request, how long we have been waiting.
    bit m_pend [NI], m_err [NI], m_arm [NI], m_prev [NI], m_inreq [NI], m_wait [NI];
    int m_cnt [NI], m_waited [NI];

    initial begin
        exp_t e;
        for (int c = 0; c < NI; c++) begin
            m_pend[c] = 0; m_err[c] = 0; m_arm[c] = 0; m_prev[c] = 0;
            m_inreq[c] = 0; m_wait[c] = 0; m_cnt[c] = 0; m_waited[c] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int c = 0; c < NI; c++) begin
                if (reset) begin
                    m_pend[c] = 0; m_err[c] = 0; m_arm[c] = 0; m_prev[c] = 0;
                    m_inreq[c] = 0; m_wait[c] = 0; m_cnt[c] = 0; m_waited[c] = 0;
                end else begin
                    bit evt, expire, go, n_inreq, n_wait;
                    int n_waited;
                    evt = irq_level_mode[c] ? (irq_in[c] && !m_pend[c]) : (irq_in[c] && !m_prev[c]);
                    expire = 0; go = 0;
                    n_inreq = m_inreq[c]; n_wait = m_wait[c]; n_waited = m_waited[c];
                    if (m_inreq[c]) begin
                        n_inreq = 0;
                        if (!irq_ack[c]) begin n_wait = 1; n_waited = 1; end
                    end else if (m_wait[c]) begin
                        if (irq_ack[c]) n_wait = 0;
                        else if (m_waited[c] == TO) begin n_wait = 0; n_inreq = 1; expire = 1; end
                        else n_waited = m_waited[c] + 1;
                    end else if (m_arm[c] && !irq_mask[c]) begin
                        n_inreq = 1; go = 1;
                    end
                    if (evt) begin
                        m_pend[c] = 1;
                        m_cnt[c]  = irq_pop[c] ? 1 : ((m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX);
                        m_arm[c]  = 1;
                    end else begin
                        if (irq_pop[c]) begin m_pend[c] = 0; m_cnt[c] = 0; end
                        if (irq_pop[c] || go) m_arm[c] = 0;
                    end
                    m_err[c]    = (m_err[c] && !irq_pop[c]) || expire;
                    m_prev[c]   = irq_in[c];
                    m_inreq[c]  = n_inreq;
                    m_wait[c]   = n_wait;
                    m_waited[c] = n_waited;
                end
                e.st[c] = m_pend[c];
                e.er[c] = m_err[c];
                e.rq[c] = m_inreq[c];
                e.cn[c*CW +: CW] = m_cnt[c][CW-1:0];
            end
            exp_q.push_back(e);
        end
    end

    // Scoreboard monitor: one expectation per clock, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                if (cyc > 0) chk("sb_queue_empty", 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                if (reset) begin
                    e.st = '0; e.er = '0; e.rq = '0; e.cn = '0;
                end
                chk("sb_status", 64'(irq_status), 64'(e.st));
                chk("sb_err",    64'(irq_err),    64'(e.er));
                chk("sb_req",    64'(irq_req),    64'(e.rq));
                chk("sb_count",  64'(irq_count),  64'(e.cn));
            end
        end
    end

    // Request pulse bookkeeping for the directed scenarios.
    initial begin
        for (int c = 0; c < NI; c++) req_cnt[c] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NI; c++) if (irq_req[c]) req_cnt[c]++;
            if (irq_req[6]) t6.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input int ch, input int bound);
        bit found;
        found = 0;
        for (int i = 0; i < bound && !found; i++) begin
            if (irq_req[ch]) found = 1;
            else tick();
        end
        if (!found && irq_req[ch]) found = 1;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_req_ch%0d: irq_req never seen in %0d cycles, expected a pulse", ch, bound);
        end
    endtask

    task automatic ack_pulse(input int ch);
        irq_ack[ch] = 1'b1;
        tick();
        irq_ack[ch] = 1'b0;
    endtask

    initial begin
        int rc;
        reset = 1'b1;
        irq_in = '0; irq_mask = '0; irq_level_mode = '0; irq_pop = '0; irq_ack = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_status", 64'(irq_status), 64'd0);
        chk("reset_count",  64'(irq_count),  64'd0);
        chk("reset_err",    64'(irq_err),    64'd0);
        chk("reset_req",    64'(irq_req),    64'd0);

        // Single edge on ch3, request two cycles after the input rises.
        irq_in[3] = 1'b1;
        tick();
        chk("edge3_status", 64'(irq_status[3]), 64'd1);
        chk("edge3_count",  64'(cnt_of(3)),     64'd1);
        chk("edge3_req_n1", 64'(irq_req[3]),    64'd0);
        irq_in[3] = 1'b0;
        tick();
        chk("edge3_req_n2", 64'(irq_req[3]), 64'd1);
        tick();
        chk("edge3_req_n3", 64'(irq_req[3]), 64'd0);
        repeat (3) tick();
        ack_pulse(3);
        rc = req_cnt[3];
        repeat (15) tick();
        chk("edge3_no_rereq", 64'(req_cnt[3] - rc), 64'd0);
        chk("edge3_err",      64'(irq_err[3]),      64'd0);

        // Coalescing: three more edges while waiting for the ack.
        rc = req_cnt[0];
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        wait_req(0, 4);
        tick();
        for (int k = 0; k < 3; k++) begin
            irq_in[0] = 1'b1;
            tick();
            irq_in[0] = 1'b0;
            tick();
        end
        ack_pulse(0);
        wait_req(0, 6);
        ack_pulse(0);
        repeat (12) tick();
        chk("coal_count", 64'(cnt_of(0)),         64'd4);
        chk("coal_reqs",  64'(req_cnt[0] - rc),   64'd2);

        // Level mode: held level counts once, re-triggers after pop.
        irq_level_mode[5] = 1'b1;
        irq_in[5] = 1'b1;
        tick();
        wait_req(5, 4);
        ack_pulse(5);
        repeat (10) tick();
        chk("lvl_count_held", 64'(cnt_of(5)), 64'd1);
        rc = req_cnt[5];
        irq_pop[5] = 1'b1;
        tick();
        irq_pop[5] = 1'b0;
        tick();
        chk("lvl_count_repop", 64'(cnt_of(5)),     64'd1);
        chk("lvl_status",      64'(irq_status[5]), 64'd1);
        wait_req(5, 4);
        ack_pulse(5);
        chk("lvl_second_req", 64'(req_cnt[5] - rc), 64'd1);
        irq_in[5] = 1'b0;
        irq_level_mode[5] = 1'b0;

        // Masked channel records the event but does not request until unmasked.
        irq_mask[2] = 1'b1;
        rc = req_cnt[2];
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        repeat (12) tick();
        chk("mask_status", 64'(irq_status[2]),   64'd1);
        chk("mask_no_req", 64'(req_cnt[2] - rc), 64'd0);
        irq_mask[2] = 1'b0;
        tick();
        chk("unmask_req", 64'(irq_req[2]), 64'd1);
        ack_pulse(2);

        // Timeout: never ack ch6, re-request every TO+1 cycles.
        t6.delete();
        irq_in[6] = 1'b1;
        tick();
        irq_in[6] = 1'b0;
        repeat (30) tick();
        if (t6.size() >= 3) begin
            chk("tmo_period_a", 64'(t6[1] - t6[0]), 64'(TO + 1));
            chk("tmo_period_b", 64'(t6[2] - t6[1]), 64'(TO + 1));
        end else begin
            chk("tmo_req_pulses", 64'(t6.size()), 64'd3);
        end
        chk("tmo_err", 64'(irq_err[6]), 64'd1);
        irq_pop[6] = 1'b1;
        tick();
        irq_pop[6] = 1'b0;
        chk("tmo_pop_err", 64'(irq_err[6]), 64'd0);
        wait_req(6, 12);
        ack_pulse(6);

        // Event and pop in the same cycle.
        for (int k = 0; k < 2; k++) begin
            irq_in[1] = 1'b1;
            tick();
            irq_in[1] = 1'b0;
            wait_req(1, 4);
            ack_pulse(1);
        end
        repeat (3) tick();
        chk("evpop_pre_count", 64'(cnt_of(1)), 64'd2);
        irq_in[1] = 1'b1;
        irq_pop[1] = 1'b1;
        tick();
        irq_in[1] = 1'b0;
        irq_pop[1] = 1'b0;
        chk("evpop_count",  64'(cnt_of(1)),     64'd1);
        chk("evpop_status", 64'(irq_status[1]), 64'd1);
        wait_req(1, 4);
        ack_pulse(1);

        // Counter saturation on a masked channel.
        irq_mask[7] = 1'b1;
        rc = req_cnt[7];
        for (int k = 0; k < 260; k++) begin
            irq_in[7] = 1'b1;
            tick();
            irq_in[7] = 1'b0;
            tick();
        end
        chk("sat_count",  64'(cnt_of(7)),         64'(CMAX));
        chk("sat_no_req", 64'(req_cnt[7] - rc),   64'd0);
        irq_pop[7] = 1'b1;
        tick();
        irq_pop[7] = 1'b0;
        irq_mask[7] = 1'b0;
        tick();

        // Asynchronous reset while ch4 waits for its ack.
        irq_in[4] = 1'b1;
        tick();
        irq_in[4] = 1'b0;
        wait_req(4, 4);
        tick();
        tick();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_status", 64'(irq_status), 64'd0);
        chk("arst_count",  64'(irq_count),  64'd0);
        chk("arst_err",    64'(irq_err),    64'd0);
        chk("arst_req",    64'(irq_req),    64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Random traffic scored by the model.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NI; c++) begin
                if ($urandom_range(3) == 0)   irq_in[c] = ~irq_in[c];
                irq_ack[c] = ($urandom_range(3) == 0);
                irq_pop[c] = ($urandom_range(39) == 0);
                if ($urandom_range(59) == 0)  irq_mask[c] = ~irq_mask[c];
                if ($urandom_range(99) == 0)  irq_level_mode[c] = ~irq_level_mode[c];
            end
            tick();
        end
        irq_in = '0; irq_ack = '0; irq_pop = '0; irq_mask = '0; irq_level_mode = '0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
